if_id_stall_ctrl: RTL and testbench
===================================

// Module: if_id_stall_ctrl
// PURPOSE
//   Consumer of the load-use stall request and the EX-stage branch redirect.
//   Owns the PC register and the IF/ID pipeline register; applies hold, flush and bubble.
//   Sits between instruction memory and decode.
//   Issues the ID/EX bubble that zeroes control signals.
// PARAMETERS
//   XLEN       32            PC / address width
//   RESET_PC   32'h0000_0000 PC value loaded on reset
//   NOP_INSTR  32'h0000_0013 instruction inserted on flush/reset (addi x0,x0,0)
//   MAX_STALL  4             consecutive stall cycles before stall_err asserts
//   CNT_W      32            width of perf counters (only with the macro)
// PORTS
//   clk            in   1     rising-edge clock
//   rst            in   1     asynchronous reset, active-high
//   stall_signal   in   1     load-use hazard request from decode-stage hazard logic
//   branch_taken   in   1     EX-stage redirect (taken branch/jump)
//   branch_target  in   XLEN  redirect address from EX
//   imem_rdata     in   32    instruction at imem_addr (combinational read)
//   imem_addr      out  XLEN  current PC
//   ifid_pc        out  XLEN  PC of instruction in IF/ID
//   ifid_instr     out  32    instruction in IF/ID
//   ifid_valid     out  1     IF/ID holds a real (non-flushed) instruction
//   idex_bubble    out  1     force ID/EX control to zero this cycle
//   stall_err      out  1     sticky: stall held > MAX_STALL cycles
//   stall_cnt      out  CNT_W stall cycles (macro only)
//   flush_cnt      out  CNT_W flush events (macro only)
// BEHAVIOUR
// - Reset (async): PC=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc=RESET_PC.
//   ifid_valid=0, stall_err=0, counters=0, FSM=RUN.
// - idex_bubble is combinational: stall_signal | branch_taken.
// - Priority per edge: branch_taken > stall_signal > normal advance.
// - Normal: PC<=PC+4 (wraps mod 2^XLEN); IF/ID<={PC,imem_rdata}, valid=1.
// - Stall (no branch): PC and IF/ID hold every bit; FSM RUN->STALL.
// - Flush: PC<={branch_target[XLEN-1:2],2'b00}; IF/ID<=NOP_INSTR, valid=0.
//   Flush wins over a coincident stall: the stalled instruction is wrong-path. FSM->RUN.
// - FSM RUN/STALL with stall-run counter scnt (clog2(MAX_STALL+1) bits, saturating).
//   Entering STALL sets scnt=1. Each further stall cycle increments it.
//   Stall deassert or flush -> RUN, scnt=0.
//   A stall cycle with scnt==MAX_STALL sets stall_err. stall_err stays set until rst.
// - Latency: a fetched instruction appears on ifid_* one cycle after imem_addr shows it.
// - Redirect penalty: 1 bubble in IF/ID plus the EX-side bubble via idex_bubble.
// - Reset mid-stall or mid-flush: all state returns to reset values immediately.
// CONFIGURATION
//   STALL_PERF_CNT_EN defined: stall_cnt +1 per edge with stall & ~branch_taken.
//     flush_cnt +1 per edge with branch_taken. Both wrap at 2^CNT_W.
//   Undefined: stall_cnt/flush_cnt ports absent, counter logic removed.
// STRUCTURE
//   Shared package/header: NOP_INSTR, RESET_PC, FSM state encodings (RUN=0, STALL=1).
//   One sub-module, pc_reg: PC flop with hold/load/increment, reused by later fetch work.
//   IF/ID register and FSM stay in this module.
// TESTING
// 1 Reset, rst=0, no hazards, 4 cycles: imem_addr 0,4,8,C.
//   ifid_pc lags by 1; ifid_valid=1 from cycle 1.
// 2 stall_signal=1 for 1 cycle at PC=8: imem_addr stays 8, ifid_* held.
//   idex_bubble=1; next cycle PC=C.
// 3 branch_taken=1, branch_target=0x103: PC=0x100 next edge.
//   ifid_instr=0x00000013, ifid_valid=0.
// 4 stall_signal=1 with branch_taken=1 (target 0x40): PC=0x40, flush taken, FSM=RUN.
// 5 stall held 5 cycles with MAX_STALL=4: stall_err rises on the 5th edge.
//   It stays 1 after the stall drops, until rst.
// 6 rst asserted mid-stall: outputs drop to reset values without a clock edge.
//   With STALL_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/if_id_stall_ctrl_pkg.sv
// Shared constants and FSM state encoding for the IF/ID stall/flush controller.
package if_id_stall_ctrl_pkg;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } stall_state_t;

endpackage

// File: rtl/if_id_stall_ctrl_pc_reg.sv
// Program counter flop: a redirect load beats hold, and hold beats the +4 increment.
module pc_reg #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            load,
  input  logic [XLEN-1:0] load_addr,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc <= RESET_PC;
    else if (load)
      pc <= load_addr;
    else if (!hold)
      pc <= pc + XLEN'(4);
  end

endmodule

// File: rtl/if_id_stall_ctrl.sv
// PC and IF/ID register owner: load-use hold, branch flush and ID/EX bubble.
// Optional perf counters (stall_cnt, flush_cnt) are built when STALL_PERF_CNT_EN is defined.
module if_id_stall_ctrl
  import if_id_stall_ctrl_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEF_RESET_PC),
  parameter logic [31:0]     NOP_INSTR = DEF_NOP_INSTR,
  parameter int              MAX_STALL = 4,
  parameter int              CNT_W     = 32
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_signal,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic [31:0]      imem_rdata,
  output logic [XLEN-1:0]  imem_addr,
  output logic [XLEN-1:0]  ifid_pc,
  output logic [31:0]      ifid_instr,
  output logic             ifid_valid,
  output logic             idex_bubble,
  output logic             stall_err
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int SW = $clog2(MAX_STALL + 1);

  stall_state_t  state, state_nxt;
  logic [SW-1:0] scnt, scnt_nxt;
  logic          err_set;
  logic          unused_bits;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == '1) ? v : v + SW'(1);
  endfunction

  assign idex_bubble = stall_signal | branch_taken;

  // Redirect targets are word aligned; the low two bits of the target are dropped.
  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .hold      (stall_signal),
    .load      (branch_taken),
    .load_addr ({branch_target[XLEN-1:2], 2'b00}),
    .pc        (imem_addr)
  );

  always_comb begin
    state_nxt = state;
    scnt_nxt  = scnt;
    err_set   = 1'b0;
    if (branch_taken) begin
      state_nxt = RUN;
      scnt_nxt  = '0;
    end else if (stall_signal) begin
      err_set = (scnt == SW'(MAX_STALL));
      if (state == RUN) begin
        state_nxt = STALL;
        scnt_nxt  = SW'(1);
      end else begin
        scnt_nxt = sat_inc(scnt);
      end
    end else begin
      state_nxt = RUN;
      scnt_nxt  = '0;
    end
  end

  // IF/ID stage boundary: flush beats hold because a stalled instruction under a redirect is wrong-path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      scnt       <= '0;
      stall_err  <= 1'b0;
      ifid_pc    <= RESET_PC;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      scnt      <= scnt_nxt;
      stall_err <= stall_err | err_set;
      if (branch_taken) begin
        ifid_pc    <= imem_addr;
        ifid_instr <= NOP_INSTR;
        ifid_valid <= 1'b0;
      end else if (!stall_signal) begin
        ifid_pc    <= imem_addr;
        ifid_instr <= imem_rdata;
        ifid_valid <= 1'b1;
      end
    end
  end

`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_signal && !branch_taken)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (branch_taken)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign unused_bits = ^branch_target[1:0];
`else
  assign unused_bits = ^{branch_target[1:0], CNT_W[0]};
`endif

endmodule

// File: tb/tb_if_id_stall_ctrl.sv
// Scoreboard bench for if_id_stall_ctrl: directed stimulus pushes expectations, a negedge monitor checks them.
module tb_if_id_stall_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_signal = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] imem_rdata, imem_addr, ifid_pc, ifid_instr;
  logic        ifid_valid, idex_bubble, stall_err;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  typedef struct {
    int          cyc;
    int          id;
    logic [31:0] val;
  } exp_t;

  exp_t  sb[$];
  int    cyc   = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  string nm[8] = '{"imem_addr", "ifid_pc", "ifid_instr", "ifid_valid",
                   "idex_bubble", "stall_err", "stall_cnt", "flush_cnt"};

  if_id_stall_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stall_signal  (stall_signal),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_rdata    (imem_rdata),
    .imem_addr     (imem_addr),
    .ifid_pc       (ifid_pc),
    .ifid_instr    (ifid_instr),
    .ifid_valid    (ifid_valid),
    .idex_bubble   (idex_bubble),
    .stall_err     (stall_err)
`ifdef STALL_PERF_CNT_EN
    ,
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  // Instruction memory stand-in: each address returns a distinct word.
  assign imem_rdata = imem_addr ^ 32'h1234_0000;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ins(input logic [31:0] a);
    return a ^ 32'h1234_0000;
  endfunction

  function automatic logic [31:0] probe(input int id);
    case (id)
      0: return imem_addr;
      1: return ifid_pc;
      2: return ifid_instr;
      3: return {31'd0, ifid_valid};
      4: return {31'd0, idex_bubble};
      5: return {31'd0, stall_err};
`ifdef STALL_PERF_CNT_EN
      6: return stall_cnt;
      7: return flush_cnt;
`endif
      default: return 'x;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp1(input int id, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc;
    e.id  = id;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic exp_core(input logic [31:0] a, input logic [31:0] p, input logic [31:0] i,
                          input logic v, input logic b, input logic er);
    exp1(0, a);
    exp1(1, p);
    exp1(2, i);
    exp1(3, {31'd0, v});
    exp1(4, {31'd0, b});
    exp1(5, {31'd0, er});
  endtask

  // The PC recorded alongside a flushed slot is not architecturally meaningful, so it is not checked.
  task automatic exp_flush(input logic [31:0] a, input logic b, input logic er);
    exp1(0, a);
    exp1(2, NOP);
    exp1(3, 32'd0);
    exp1(4, {31'd0, b});
    exp1(5, {31'd0, er});
  endtask

  task automatic exp_cnt(input logic [31:0] s, input logic [31:0] f);
`ifdef STALL_PERF_CNT_EN
    exp1(6, s);
    exp1(7, f);
`else
    if (s === 32'hFFFF_FFFF && f === 32'hFFFF_FFFF) $display("unexpected counter request");
`endif
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (e.cyc != cyc || probe(e.id) !== e.val) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: got %h, expected %h", nm[e.id], e.cyc, probe(e.id), e.val);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // Reset state
    step();
    exp_core(32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0);
    exp_cnt(0, 0);
    rst = 1'b0;
    // Free-running fetch
    step(); exp_core(32'h4, 32'h0, ins(32'h0), 1'b1, 1'b0, 1'b0);
    step(); stall_signal = 1'b1;
    exp_core(32'h8, 32'h4, ins(32'h4), 1'b1, 1'b1, 1'b0);
    // Single-cycle load-use stall at PC=8
    step(); stall_signal = 1'b0;
    exp_core(32'h8, 32'h4, ins(32'h4), 1'b1, 1'b0, 1'b0);
    step(); branch_taken = 1'b1; branch_target = 32'h103;
    exp_core(32'hC, 32'h8, ins(32'h8), 1'b1, 1'b1, 1'b0);
    // Redirect to 0x103 lands word-aligned at 0x100 with a flushed slot
    step(); branch_taken = 1'b0;
    exp_flush(32'h100, 1'b0, 1'b0);
    step(); stall_signal = 1'b1;
    exp_core(32'h104, 32'h100, ins(32'h100), 1'b1, 1'b1, 1'b0);
    step(); exp_core(32'h104, 32'h100, ins(32'h100), 1'b1, 1'b1, 1'b0);
    step(); exp_core(32'h104, 32'h100, ins(32'h100), 1'b1, 1'b1, 1'b0);
    step(); branch_taken = 1'b1; branch_target = 32'h40;
    exp_core(32'h104, 32'h100, ins(32'h100), 1'b1, 1'b1, 1'b0);
    // Stall and branch together: flush wins and the stall run restarts
    step(); stall_signal = 1'b0; branch_taken = 1'b0;
    exp_flush(32'h40, 1'b0, 1'b0);
    step(); stall_signal = 1'b1;
    exp_core(32'h44, 32'h40, ins(32'h40), 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(); exp_core(32'h44, 32'h40, ins(32'h40), 1'b1, 1'b1, 1'b0);
    end
    // Fifth consecutive stall edge raises the sticky error
    step(); stall_signal = 1'b0;
    exp_core(32'h44, 32'h40, ins(32'h40), 1'b1, 1'b0, 1'b1);
    step(); exp_core(32'h48, 32'h44, ins(32'h44), 1'b1, 1'b0, 1'b1);
    step(); stall_signal = 1'b1;
    exp_core(32'h4C, 32'h48, ins(32'h48), 1'b1, 1'b1, 1'b1);
    exp_cnt(9, 2);
    // Asynchronous reset in the middle of a stall, between clock edges
    step(); #2; rst = 1'b1; stall_signal = 1'b0;
    exp_core(32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0);
    exp_cnt(0, 0);
    step(); rst = 1'b0;
    exp_core(32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0);
    step(); exp_core(32'h4, 32'h0, ins(32'h0), 1'b1, 1'b0, 1'b0);
    step(); step();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
